ps_rr_scheduler: RTL and testbench
==================================

Name: ps_rr_scheduler

Overview:
- Round-robin scheduler that shares one parallel-to-serial serializer among REQ_NUM score producers, e.g. per-bank classifier accumulators in the BWN output stage.
- Arbitrates requests and latches the winner's CLASS_NUM*D_WL score vector.
- Fires a one-cycle load enable to the serializer, then tracks the serializer's output-valid stream to detect completion before granting the next requester.
- Reports the active requester ID so downstream logic can tag the serial words.

Parameters:
- D_WL, 24: score word width in bits.
- CLASS_NUM, 2: words per vector; serializer beats per job.
- REQ_NUM, 4: number of requesters; 2..16.
- TIMEOUT, 64: maximum cycles in WAIT_V or STREAM before abort; must be greater than CLASS_NUM+4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  REQ_NUM  level request per requester; held until its ack.
- req_data  in  REQ_NUM*CLASS_NUM*D_WL  vectors; requester i occupies slice [i*CLASS_NUM*D_WL +: CLASS_NUM*D_WL].
- ack  out  REQ_NUM  one-hot, one-cycle pulse; the winner's data is captured on this edge.
- ps_en  out  1  one-cycle load enable to the serializer.
- ps_din  out  CLASS_NUM*D_WL  registered vector to the serializer.
- ps_valid  in  1  serializer output-valid.
- busy  out  1  high in every state except IDLE.
- cur_id  out  $clog2(REQ_NUM)  ID of the active job; holds its last value when idle.
- done  out  1  one-cycle pulse at job completion.
- err_timeout  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; the clock is clk.
- Reset values: all outputs 0, FSM in IDLE, rr_ptr=0, timer=0, beat counter=0.
- A reset mid-job abandons the job and issues no done.
- FSM states: IDLE, LOAD, WAIT_V, STREAM, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from rr_ptr and wrapping modulo REQ_NUM.
  - On that edge: register its slice into ps_din, set cur_id, pulse ack[id], go to LOAD.
  - With no request, stay in IDLE.
- LOAD: ps_en=1 for exactly this one cycle (ps_din is already stable); clear timer; go to WAIT_V.
- WAIT_V:
  - When ps_valid=1, go to STREAM; that cycle counts as beat 1.
  - If timer reaches TIMEOUT-1, set err_timeout and go to DONE.
- STREAM:
  - Count cycles with ps_valid=1.
  - When ps_valid falls to 0, go to DONE.
  - If timer reaches TIMEOUT-1, set err_timeout and go to DONE.
- DONE: done=1 for one cycle; rr_ptr = cur_id+1 modulo REQ_NUM; go to IDLE.
- Minimum spacing between consecutive ps_en pulses: CLASS_NUM+5 cycles.
- Fixed latencies:
  - Request-to-ack: 1 cycle.
  - Ack-to-ps_en: 1 cycle.
- ps_din holds its value from the ack edge until the next grant. It is not cleared in DONE.
- A request that drops before it is granted is ignored. No ack is issued for it.
- The granted requester must deassert req in the cycle after ack.
  - A req still high in IDLE is treated as a new request.
  - The round-robin pointer prevents starvation.
- Multiple simultaneous requests: a full rotation completes in REQ_NUM jobs.
- ps_valid=1 while in IDLE or LOAD is ignored.
- rr_ptr wrap: REQ_NUM-1 wraps to 0.

Optional Feature:
- Macro: PS_BEAT_CHECK_EN.
- Enabled:
  - Add an output err_beat (1 bit, sticky, reset 0).
  - Set it in DONE when the counted ps_valid beats differ from CLASS_NUM, or when the job ended by timeout.
- Disabled: the err_beat port and the beat counter are absent.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package bwn_ps_pkg holds:
  - The state enum: IDLE=0, LOAD=1, WAIT_V=2, STREAM=3, DONE=4, 3-bit encoding.
  - The ID width function.
  - Default constants D_WL_DEF=24 and CLASS_NUM_DEF=2.
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: req and rr_ptr.
  - Outputs: grant_vld and grant_id.
  - Verified standalone.

Test Plan:
- Single job: req=4'b0010, data vector {24'h00ABCD, 24'h001234}. Required response:
  - ack[1] pulses at cycle t+1.
  - ps_en pulses at t+2 with ps_din equal to that vector.
  - A serializer model gives 2 valid beats.
  - done pulses once; cur_id=1; rr_ptr=2.
- Fairness: req=4'b1111 held, each requester dropping its req after ack. Required response:
  - Grant order 0,1,2,3, then 0 when requester 0 re-requests.
  - No ack while busy.
- Wrap: rr_ptr=3 with req=4'b1001. Required response: grant 3 first, then 0.
- Timeout: serializer model never raises ps_valid. Required response:
  - err_timeout=1 exactly 64 cycles after ps_en.
  - done pulses; the next request is still serviced.
- Reset mid-STREAM: assert rst_n=0 during beat 1. Required response:
  - All outputs 0 immediately.
  - No done; the FSM restarts in IDLE.
- With PS_BEAT_CHECK_EN: the model emits 3 beats for CLASS_NUM=2. Required response: err_beat=1 after done; a 2-beat job leaves it at 0 from reset.

Source files
------------

// File: rtl/bwn_ps_pkg.sv
// Shared types and constants for the BWN parallel-to-serial scheduling slice.
package bwn_ps_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT_V = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } ps_state_e;

  localparam int D_WL_DEF      = 24;
  localparam int CLASS_NUM_DEF = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_rr_scheduler_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above rr_ptr, wrapping.
module rr_pick
  import bwn_ps_pkg::*;
#(
  parameter int  REQ_NUM = 4,
  localparam int IW      = id_w(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               grant_vld,
  output logic [IW-1:0]      grant_id
);

  // idx[k] is the requester visited k steps after rr_ptr
  logic [REQ_NUM-1:0][IW-1:0] idx;

  for (genvar k = 0; k < REQ_NUM; k++) begin : g_idx
    assign idx[k] = IW'((int'(rr_ptr) + k) % REQ_NUM);
  end

  // scan from the far end so the closest hit to rr_ptr wins
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (req[idx[k]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[k];
      end
    end
  end

endmodule

// File: rtl/ps_rr_scheduler.sv
// Round-robin sharing of one serializer among REQ_NUM score producers.
// Optional PS_BEAT_CHECK_EN adds a sticky err_beat on wrong beat count or timeout.
module ps_rr_scheduler
  import bwn_ps_pkg::*;
#(
  parameter int  D_WL      = D_WL_DEF,
  parameter int  CLASS_NUM = CLASS_NUM_DEF,
  parameter int  REQ_NUM   = 4,
  parameter int  TIMEOUT   = 64,
  localparam int VW        = CLASS_NUM * D_WL,
  localparam int IW        = id_w(REQ_NUM),
  localparam int TW        = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_NUM-1:0]    req,
  input  logic [REQ_NUM*VW-1:0] req_data,
  output logic [REQ_NUM-1:0]    ack,
  output logic                  ps_en,
  output logic [VW-1:0]         ps_din,
  input  logic                  ps_valid,
  output logic                  busy,
  output logic [IW-1:0]         cur_id,
  output logic                  done,
`ifdef PS_BEAT_CHECK_EN
  output logic                  err_beat,
`endif
  output logic                  err_timeout
);

  ps_state_e     state;
  logic          grant_vld;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] rr_ptr;
  logic [TW-1:0] timer;
  logic          timed_out;
`ifdef PS_BEAT_CHECK_EN
  logic [TW:0]   beats;
  logic          job_to;
`endif

  assign timed_out = (timer == TW'(TIMEOUT - 1));

  rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack         <= '0;
      ps_en       <= 1'b0;
      ps_din      <= '0;
      busy        <= 1'b0;
      cur_id      <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      rr_ptr      <= '0;
      timer       <= '0;
`ifdef PS_BEAT_CHECK_EN
      beats       <= '0;
      job_to      <= 1'b0;
      err_beat    <= 1'b0;
`endif
    end else begin
      ack   <= '0;
      ps_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (grant_vld) begin
          ps_din <= req_data[grant_id*VW +: VW];
          cur_id <= grant_id;
          ack    <= REQ_NUM'(1) << grant_id;
          busy   <= 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          ps_en <= 1'b1;
          timer <= '0;
`ifdef PS_BEAT_CHECK_EN
          beats  <= '0;
          job_to <= 1'b0;
`endif
          state <= WAIT_V;
        end
        WAIT_V: begin
          timer <= timer + 1'b1;
          if (timed_out) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
`ifdef PS_BEAT_CHECK_EN
            job_to      <= 1'b1;
`endif
          end else if (ps_valid) begin
`ifdef PS_BEAT_CHECK_EN
            beats <= (TW+1)'(1);
`endif
            state <= STREAM;
          end
        end
        STREAM: begin
          timer <= timer + 1'b1;
          if (timed_out) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
`ifdef PS_BEAT_CHECK_EN
            job_to      <= 1'b1;
`endif
          end else if (ps_valid) begin
`ifdef PS_BEAT_CHECK_EN
            beats <= beats + 1'b1;
`endif
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= (cur_id == IW'(REQ_NUM - 1)) ? '0 : cur_id + 1'b1;
          busy   <= 1'b0;
`ifdef PS_BEAT_CHECK_EN
          if (job_to || beats != (TW+1)'(CLASS_NUM)) err_beat <= 1'b1;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_rr_scheduler.sv
// Self-checking bench for ps_rr_scheduler: vector table, corner sequences, random vs. model.
module tb_ps_rr_scheduler;

  localparam int RN = 4;
  localparam int VW = 48;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [RN-1:0]   req;
  logic [RN*VW-1:0] req_data;
  logic [RN-1:0]   ack;
  logic            ps_en;
  logic [VW-1:0]   ps_din;
  logic            ps_valid;
  logic            busy;
  logic [1:0]      cur_id;
  logic            done;
  logic            err_timeout;
`ifdef PS_BEAT_CHECK_EN
  logic            err_beat;
`endif

  int total = 0;
  int bad   = 0;
  int ser_beats = 2;
  int ser_cnt   = 0;

  always #5 clk = ~clk;

  ps_rr_scheduler #(.D_WL(24), .CLASS_NUM(2), .REQ_NUM(RN), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .ps_en       (ps_en),
    .ps_din      (ps_din),
    .ps_valid    (ps_valid),
    .busy        (busy),
    .cur_id      (cur_id),
    .done        (done),
`ifdef PS_BEAT_CHECK_EN
    .err_beat    (err_beat),
`endif
    .err_timeout (err_timeout)
  );

  // serializer model: ser_beats valid cycles starting the cycle after ps_en
  initial begin
    ps_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ser_cnt > 0) begin
        ps_valid = 1'b1;
        ser_cnt--;
      end else ps_valid = 1'b0;
      if (ps_en) ser_cnt = ser_beats;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [VW-1:0] slice(input int i);
    return req_data[i*VW +: VW];
  endfunction

  // one complete job; req must already be driven while the DUT is idle
  task automatic run_job(input int exp_id, input bit drop_all);
    logic [VW-1:0] exp_data;
    int n;
    int extra;
    exp_data = slice(exp_id);
    n = 0;
    do begin tick; n++; end while (ack == '0 && n < 20);
    chk("req_to_ack", n, 1);
    chk("ack_onehot", ack, 64'(1) << exp_id);
    chk("ack_cur_id", cur_id, exp_id);
    chk("ack_ps_din", ps_din, exp_data);
    chk("ack_busy", busy, 1);
    chk("ack_no_en", ps_en, 0);
    if (drop_all) req = '0;
    else req = req & ~ack;
    tick;
    chk("ack_to_en", ps_en, 1);
    chk("en_ack_clear", ack, 0);
    n = 0; extra = 0;
    while (!done && n < 200) begin
      tick; n++;
      if (ack != '0) extra++;
    end
    chk("done_seen", done, 1);
    chk("no_ack_busy", extra, 0);
    chk("done_cur_id", cur_id, exp_id);
    tick;
    chk("done_one_cycle", done, 0);
    chk("back_idle", busy, 0);
    chk("din_held", ps_din, exp_data);
  endtask

  typedef struct {
    logic [RN-1:0] rq;
    int            exp_id;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    int cnt;
    int mp;
    int exp;
    logic [RN-1:0] pm;
    logic [63:0] r;

    tbl[0] = '{rq: 4'b0010, exp_id: 1};
    tbl[1] = '{rq: 4'b0001, exp_id: 0};
    tbl[2] = '{rq: 4'b1001, exp_id: 3};
    tbl[3] = '{rq: 4'b1001, exp_id: 0};
    tbl[4] = '{rq: 4'b0110, exp_id: 1};
    tbl[5] = '{rq: 4'b0110, exp_id: 2};
    tbl[6] = '{rq: 4'b0100, exp_id: 2};
    tbl[7] = '{rq: 4'b1001, exp_id: 3};
    tbl[8] = '{rq: 4'b1001, exp_id: 0};
    tbl[9] = '{rq: 4'b1000, exp_id: 3};

    rst_n = 1'b0;
    req   = '0;
    req_data[0  +: VW] = 48'h111111_222222;
    req_data[48 +: VW] = {24'h00ABCD, 24'h001234};
    req_data[96 +: VW] = 48'h333333_444444;
    req_data[144+: VW] = 48'h555555_666666;
    tick; tick;
    chk("rst_ack", ack, 0);
    chk("rst_ps_en", ps_en, 0);
    chk("rst_ps_din", ps_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_done", done, 0);
    chk("rst_err_timeout", err_timeout, 0);
    rst_n = 1'b1;
    tick;

    // vector table from a fresh pointer of 0; ends with pointer back at 0
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].rq;
      run_job(tbl[i].exp_id, 1'b1);
    end

    // fairness: all request, requester 0 re-requests right after its job
    req = 4'b1111;
    run_job(0, 1'b0);
    req[0] = 1'b1;
    run_job(1, 1'b0);
    run_job(2, 1'b0);
    run_job(3, 1'b0);
    run_job(0, 1'b0);
    chk("fair_req_drained", req, 0);

    // timeout: serializer never answers (pointer is 1 here)
    ser_beats = 0;
    req = 4'b0100;
    n = 0;
    do begin tick; n++; end while (ack == '0 && n < 20);
    chk("to_ack", ack, 4'b0100);
    req = '0;
    tick;
    chk("to_ps_en", ps_en, 1);
    n = 0;
    while (!err_timeout && n < 200) begin tick; n++; end
    chk("to_cycles", n, 64);
    chk("to_done", done, 1);
    tick;
    chk("to_idle", busy, 0);
    chk("to_sticky", err_timeout, 1);
    ser_beats = 2;
    req = 4'b0001;
    run_job(0, 1'b1);
    chk("to_sticky_after", err_timeout, 1);

    // reset during beat 1 of a stream (pointer is 1 here)
    req = 4'b0010;
    tick;
    chk("rs_ack", ack, 4'b0010);
    req = '0;
    tick;
    chk("rs_ps_en", ps_en, 1);
    tick; #1;
    chk("rs_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_ack0", ack, 0);
    chk("rs_en0", ps_en, 0);
    chk("rs_din0", ps_din, 0);
    chk("rs_busy0", busy, 0);
    chk("rs_id0", cur_id, 0);
    chk("rs_done0", done, 0);
    chk("rs_err0", err_timeout, 0);
    tick; tick;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done || busy) cnt++;
    end
    chk("rs_no_done", cnt, 0);
    req = 4'b1001;
    run_job(0, 1'b1);

`ifdef PS_BEAT_CHECK_EN
    chk("beat_ok_2", err_beat, 0);
    ser_beats = 3;
    req = 4'b0100;
    run_job(2, 1'b1);
    chk("beat_err_3", err_beat, 1);
    ser_beats = 2;
    mp = 3;
`else
    mp = 1;
`endif

    // random traffic against a pending-set / pointer model
    pm = '0;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < RN; i++) begin
        if (!pm[i] && $urandom_range(1, 0) == 1) begin
          pm[i] = 1'b1;
          r = {$urandom(), $urandom()};
          req_data[i*VW +: VW] = r[VW-1:0];
        end
      end
      if (pm == '0) begin
        n = $urandom_range(RN-1, 0);
        pm[n] = 1'b1;
        r = {$urandom(), $urandom()};
        req_data[n*VW +: VW] = r[VW-1:0];
      end
      exp = -1;
      for (int k = 0; k < RN; k++) begin
        if (exp < 0 && pm[(mp + k) % RN]) exp = (mp + k) % RN;
      end
      ser_beats = $urandom_range(4, 1);
      req = pm;
      run_job(exp, 1'b0);
      pm[exp] = 1'b0;
      mp = (exp + 1) % RN;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
